// File: rtl/mem_resp_router_pkg.sv
// ----------------------------------------------------------------------------
// mem_resp_router_pkg : shared core-ID types and grant encode/decode helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_resp_router_pkg;

  localparam int NUM_OF_CORES = 4;
  localparam int CORE_ID_W    = $clog2(NUM_OF_CORES);
  localparam int DATA_WIDTH   = 64;

  typedef logic [CORE_ID_W-1:0] core_id_t;

  // OR-reduction of set-bit indices; exact only for one-hot inputs
  function automatic core_id_t onehot_to_bin(input logic [NUM_OF_CORES-1:0] oh);
    core_id_t b;
    b = '0;
    for (int i = 0; i < NUM_OF_CORES; i++) begin
      if (oh[i]) b = b | core_id_t'(i);
    end
    return b;
  endfunction

  function automatic logic [NUM_OF_CORES-1:0] bin_to_onehot(input core_id_t b);
    logic [NUM_OF_CORES-1:0] oh;
    oh    = '0;
    oh[b] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_router_id_fifo.sv
// ----------------------------------------------------------------------------
// id_fifo : synchronous FIFO of core IDs recording grant order
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module id_fifo
  import mem_resp_router_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  core_id_t         push_id,
  input  logic             pop,
  output core_id_t         head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  core_id_t         mem_q [DEPTH];
  core_id_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_id;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
    if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_resp_router.sv
// ----------------------------------------------------------------------------
// mem_resp_router : steers in-order memory responses back to the granted core
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_resp_router #(
  parameter int NUM_OF_CORES      = mem_resp_router_pkg::NUM_OF_CORES,
  parameter int DATA_WIDTH        = mem_resp_router_pkg::DATA_WIDTH,
  parameter int OUTSTANDING_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_OF_CORES-1:0]              grant,
  output logic                                 id_full,
  input  logic                                 mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                mem_resp_data,
  output logic                                 mem_resp_ready,
  output logic [NUM_OF_CORES-1:0]              core_resp_valid,
  output logic [DATA_WIDTH-1:0]                core_resp_data,
  input  logic [NUM_OF_CORES-1:0]              core_resp_ready,
  output logic [$clog2(OUTSTANDING_DEPTH):0]   outstanding,
  output logic                                 err_overflow,
  output logic                                 err_orphan,
  output logic                                 err_onehot
);

  import mem_resp_router_pkg::*;

  core_id_t                         fifo_head;
  logic [$clog2(OUTSTANDING_DEPTH):0] fifo_count;
  logic                             fifo_full, fifo_empty;
  logic                             grant_any, grant_onehot, push, accept, out_free;

  logic                  out_valid_q, out_valid_d;
  core_id_t              out_dest_q, out_dest_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_orphan_q, err_orphan_d;
  logic                  err_onehot_q, err_onehot_d;

  assign grant_any    = |grant;
  assign grant_onehot = grant_any && ((grant & (grant - NUM_OF_CORES'(1))) == '0);
  // Full is judged on the registered count: a same-cycle pop does not make room
  assign push         = grant_onehot && !fifo_full;

  assign out_free       = !out_valid_q || core_resp_ready[out_dest_q];
  assign mem_resp_ready = out_free && !fifo_empty;
  assign accept         = mem_resp_valid && mem_resp_ready;

  id_fifo #(
    .DEPTH(OUTSTANDING_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .push_id(onehot_to_bin(grant)),
    .pop    (accept),
    .head   (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_dest_d  = out_dest_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_dest_d  = fifo_head;
      out_data_d  = mem_resp_data;
    end else if (out_valid_q && core_resp_ready[out_dest_q]) begin
      out_valid_d = 1'b0;
    end
    err_overflow_d = err_overflow_q || (grant_onehot && fifo_full);
    err_orphan_d   = err_orphan_q || (mem_resp_valid && fifo_empty);
    err_onehot_d   = err_onehot_q || (grant_any && !grant_onehot);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_dest_q     <= '0;
      out_data_q     <= '0;
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
      err_onehot_q   <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_dest_q     <= out_dest_d;
      out_data_q     <= out_data_d;
      err_overflow_q <= err_overflow_d;
      err_orphan_q   <= err_orphan_d;
      err_onehot_q   <= err_onehot_d;
    end
  end

  assign core_resp_valid = out_valid_q ? bin_to_onehot(out_dest_q) : '0;
  assign core_resp_data  = out_data_q;
  assign id_full         = fifo_full;
  assign outstanding     = fifo_count;
  assign err_overflow    = err_overflow_q;
  assign err_orphan      = err_orphan_q;
  assign err_onehot      = err_onehot_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_resp_router.sv
// ----------------------------------------------------------------------------
// tb_mem_resp_router : table vectors plus scoreboard bench for mem_resp_router
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_resp_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  grant = '0;
  logic        id_full;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        mem_resp_ready;
  logic [3:0]  core_resp_valid;
  logic [63:0] core_resp_data;
  logic [3:0]  core_resp_ready = '0;
  logic [3:0]  outstanding;
  logic        err_overflow, err_orphan, err_onehot;

  always #5 clk = ~clk;

  mem_resp_router dut (
    .clk            (clk),
    .reset          (reset),
    .grant          (grant),
    .id_full        (id_full),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_ready (mem_resp_ready),
    .core_resp_valid(core_resp_valid),
    .core_resp_data (core_resp_data),
    .core_resp_ready(core_resp_ready),
    .outstanding    (outstanding),
    .err_overflow   (err_overflow),
    .err_orphan     (err_orphan),
    .err_onehot     (err_onehot)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          dest;
    logic [63:0] data;
  } sb_t;

  typedef struct {
    logic [3:0]  g;
    logic        mv;
    logic [63:0] md;
    logic [3:0]  rdy;
    logic [3:0]  ev;
    logic [63:0] ed;
    logic        er;
    int          eo;
  } vec_t;

  sb_t  sb[$];
  int   ids[$];
  bit   m_ovf, m_orph, m_oh;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    ids.delete();
    sb.delete();
    m_ovf  = 0;
    m_orph = 0;
    m_oh   = 0;
  endtask

  // Apply inputs, compare against the reference model, then step the model
  task automatic drive(input logic [3:0] g, input logic mv, input logic [63:0] md,
                       input logic [3:0] rdy);
    logic [3:0] exp_v;
    bit         exp_r;
    int         pre;
    grant           = g;
    mem_resp_valid  = mv;
    mem_resp_data   = md;
    core_resp_ready = rdy;
    #1;
    exp_v = '0;
    if (sb.size() > 0) exp_v[sb[0].dest] = 1'b1;
    check("core_resp_valid", core_resp_valid, exp_v);
    if (sb.size() > 0) begin
      check("core_resp_data", core_resp_data, sb[0].data);
      if (rdy[sb[0].dest]) void'(sb.pop_front());
    end
    exp_r = (sb.size() == 0) && (ids.size() > 0);
    check("mem_resp_ready", mem_resp_ready, exp_r);
    check("outstanding", outstanding, ids.size());
    check("id_full", id_full, ids.size() == 8);
    check("err_overflow", err_overflow, m_ovf);
    check("err_orphan", err_orphan, m_orph);
    check("err_onehot", err_onehot, m_oh);
    pre = ids.size();
    if (mv && pre == 0) m_orph = 1;
    if (mv && exp_r) sb.push_back('{ids.pop_front(), md});
    if ($countones(g) == 1) begin
      if (pre < 8) ids.push_back(oh_idx(g));
      else m_ovf = 1;
    end else if (g != 0) begin
      m_oh = 1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [3:0] g, input logic mv, input logic [63:0] md,
                       input logic [3:0] rdy);
    drive(g, mv, md, rdy);
    advance();
  endtask

  task automatic do_reset();
    grant = '0;
    mem_resp_valid = 1'b0;
    core_resp_ready = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0001, 1'b0, 64'h0,                4'hF, 4'b0000, 64'h0,                1'b0, 0};
    tbl[1] = '{4'b0100, 1'b0, 64'h0,                4'hF, 4'b0000, 64'h0,                1'b1, 1};
    tbl[2] = '{4'b0010, 1'b0, 64'h0,                4'hF, 4'b0000, 64'h0,                1'b1, 2};
    tbl[3] = '{4'b1000, 1'b0, 64'h0,                4'hF, 4'b0000, 64'h0,                1'b1, 3};
    tbl[4] = '{4'b0000, 1'b1, 64'hD0D0_0000_0000_0000, 4'hF, 4'b0000, 64'h0,             1'b1, 4};
    tbl[5] = '{4'b0000, 1'b1, 64'hD0D0_0000_0000_0001, 4'hF, 4'b0001, 64'hD0D0_0000_0000_0000, 1'b1, 3};
    tbl[6] = '{4'b0000, 1'b1, 64'hD0D0_0000_0000_0002, 4'hF, 4'b0100, 64'hD0D0_0000_0000_0001, 1'b1, 2};
    tbl[7] = '{4'b0000, 1'b1, 64'hD0D0_0000_0000_0003, 4'hF, 4'b0010, 64'hD0D0_0000_0000_0002, 1'b1, 1};
    tbl[8] = '{4'b0000, 1'b0, 64'h0,                4'hF, 4'b1000, 64'hD0D0_0000_0000_0003, 1'b0, 0};
    tbl[9] = '{4'b0000, 1'b0, 64'h0,                4'hF, 4'b0000, 64'h0,                1'b0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst core_resp_valid", core_resp_valid, 0);
    check("rst core_resp_data", core_resp_data, 0);
    check("rst mem_resp_ready", mem_resp_ready, 0);
    check("rst outstanding", outstanding, 0);
    check("rst id_full", id_full, 0);
    check("rst errors", {err_overflow, err_orphan, err_onehot}, 0);
    reset = 1'b0;
    model_reset();
    cycle(4'b0000, 1'b0, 64'h0, 4'hF);

    // Reset asserted mid-burst with a response held at the output
    cycle(4'b0010, 1'b0, 64'h0, 4'h0);
    cycle(4'b0010, 1'b0, 64'h0, 4'h0);
    cycle(4'b0000, 1'b1, 64'hAAAA, 4'h0);
    drive(4'b0100, 1'b1, 64'hBBBB, 4'h0);
    check("pre-reset valid", core_resp_valid, 4'b0010);
    reset = 1'b1;
    #1;
    check("async rst valid", core_resp_valid, 0);
    check("async rst outstanding", outstanding, 0);
    check("async rst ready", mem_resp_ready, 0);
    for (int k = 0; k < 2; k++) begin
      advance();
      check("in-rst valid", core_resp_valid, 0);
      check("in-rst data", core_resp_data, 0);
      check("in-rst outstanding", outstanding, 0);
      check("in-rst ready", mem_resp_ready, 0);
    end
    grant = '0;
    mem_resp_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (3) cycle(4'b0000, 1'b0, 64'h0, 4'hF);

    // In-order steering, back-to-back
    foreach (tbl[i]) begin
      drive(tbl[i].g, tbl[i].mv, tbl[i].md, tbl[i].rdy);
      check("tbl valid", core_resp_valid, tbl[i].ev);
      check("tbl ready", mem_resp_ready, tbl[i].er);
      check("tbl outstanding", outstanding, tbl[i].eo);
      if (tbl[i].ev != 0) check("tbl data", core_resp_data, tbl[i].ed);
      advance();
    end

    // Fill to depth, overflow, then one response frees a slot
    for (int k = 0; k < 8; k++) cycle(4'b0100, 1'b0, 64'h0, 4'hF);
    drive(4'b0100, 1'b0, 64'h0, 4'hF);
    check("fill id_full", id_full, 1);
    check("fill outstanding", outstanding, 8);
    advance();
    drive(4'b0000, 1'b1, 64'hE000, 4'hF);
    check("ovf flag", err_overflow, 1);
    check("ovf outstanding", outstanding, 8);
    advance();
    drive(4'b0000, 1'b0, 64'h0, 4'hF);
    check("after pop id_full", id_full, 0);
    advance();
    for (int k = 1; k < 8; k++) cycle(4'b0000, 1'b1, 64'hE000 + 64'(k), 4'hF);
    repeat (2) cycle(4'b0000, 1'b0, 64'h0, 4'hF);

    // Backpressure on core 1
    do_reset();
    cycle(4'b0010, 1'b0, 64'h0, 4'h0);
    cycle(4'b0010, 1'b0, 64'h0, 4'h0);
    cycle(4'b0000, 1'b1, 64'hB0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 1'b1, 64'hB1, 4'h0);
      check("bp held valid", core_resp_valid, 4'b0010);
      check("bp held data", core_resp_data, 64'hB0);
      check("bp ready low", mem_resp_ready, 0);
      advance();
    end
    drive(4'b0000, 1'b1, 64'hB1, 4'b0010);
    check("bp release ready", mem_resp_ready, 1);
    advance();
    drive(4'b0000, 1'b0, 64'h0, 4'b0010);
    check("bp second valid", core_resp_valid, 4'b0010);
    check("bp second data", core_resp_data, 64'hB1);
    advance();
    cycle(4'b0000, 1'b0, 64'h0, 4'hF);

    // Orphan response
    drive(4'b0000, 1'b1, 64'hDEAD, 4'hF);
    check("orphan ready", mem_resp_ready, 0);
    advance();
    drive(4'b0000, 1'b0, 64'h0, 4'hF);
    check("orphan flag", err_orphan, 1);
    check("orphan no valid", core_resp_valid, 0);
    advance();

    // Multi-bit grant, then simultaneous push and pop at count 3
    cycle(4'b0001, 1'b0, 64'h0, 4'hF);
    cycle(4'b0010, 1'b0, 64'h0, 4'hF);
    cycle(4'b0011, 1'b0, 64'h0, 4'hF);
    drive(4'b0100, 1'b0, 64'h0, 4'hF);
    check("onehot flag", err_onehot, 1);
    check("onehot outstanding", outstanding, 2);
    advance();
    drive(4'b1000, 1'b1, 64'hC0, 4'hF);
    check("pushpop before", outstanding, 3);
    advance();
    drive(4'b0000, 1'b1, 64'hC1, 4'hF);
    check("pushpop after", outstanding, 3);
    check("pushpop first dest", core_resp_valid, 4'b0001);
    advance();
    cycle(4'b0000, 1'b1, 64'hC2, 4'hF);
    cycle(4'b0000, 1'b1, 64'hC3, 4'hF);
    repeat (2) cycle(4'b0000, 1'b0, 64'h0, 4'hF);
    check("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
